// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32 base core: sequences fetch/decode/execute/memory/writeback
// over a single req/ready memory port, with a bus watchdog and a sticky trap state.
module rv_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_control,
    output logic [1:0]  result_src,
    output logic        reg_write,
    output logic        inst_done,
    output logic        halted,
    output logic [1:0]  err_code,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    localparam logic [7:0] WDOG_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    state_t      state_q, state_d;
    logic [7:0]  wdog_q, wdog_d;
    logic [1:0]  err_q, err_d;

    logic        req_s, we_s, adr_s, irw_s, pcw_s, rw_s, done_s, halt_s;
    logic [1:0]  src_a_s, src_b_s, res_s;
    logic [3:0]  alu_s;
    logic        in_mem_s, timeout_s;
    logic        unused_s;

    assign unused_s  = ^{inst[31], inst[29:15], inst[11:7]};
    assign in_mem_s  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timeout_s = (wdog_q == WDOG_LAST) && !mem_ready;

    // State, watchdog and error-code registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wdog_q  <= 8'd0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        req_s   = 1'b0;
        we_s    = 1'b0;
        adr_s   = 1'b0;
        irw_s   = 1'b0;
        pcw_s   = 1'b0;
        rw_s    = 1'b0;
        done_s  = 1'b0;
        halt_s  = 1'b0;
        src_a_s = 2'b00;
        src_b_s = 2'b00;
        res_s   = 2'b00;
        alu_s   = 4'b0010;
        case (state_q)
            S_FETCH: begin
                req_s   = 1'b1;
                src_b_s = 2'b10;
                res_s   = 2'b10;
                if (mem_ready) begin
                    irw_s   = 1'b1;
                    pcw_s   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                src_a_s = 2'b01;
                src_b_s = 2'b01;
                case (inst[6:0])
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXEC_R;
                    7'b1100011:             state_d = S_BEQ;
                    default: begin
                        state_d = S_TRAP;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a_s = 2'b10;
                src_b_s = 2'b01;
                state_d = inst[5] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                req_s = 1'b1;
                adr_s = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                rw_s    = 1'b1;
                res_s   = 2'b01;
                done_s  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                req_s = 1'b1;
                we_s  = 1'b1;
                adr_s = 1'b1;
                if (mem_ready) begin
                    done_s  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout_s) begin
                    state_d = S_TRAP;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXEC_R: begin
                src_a_s = 2'b10;
                src_b_s = 2'b00;
                state_d = S_ALUWB;
                case ({inst[30], inst[14:12]})
                    4'b0000: alu_s = 4'b0010;
                    4'b1000: alu_s = 4'b0110;
                    4'b0111: alu_s = 4'b0000;
                    4'b0110: alu_s = 4'b0001;
                    default: begin
                        state_d = S_TRAP;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            S_ALUWB: begin
                rw_s    = 1'b1;
                done_s  = 1'b1;
                state_d = S_FETCH;
            end
            S_BEQ: begin
                src_a_s = 2'b10;
                src_b_s = 2'b00;
                alu_s   = 4'b0110;
                if (inst[14:12] == 3'b000) begin
                    pcw_s   = zero;
                    done_s  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                    err_d   = ERR_ILLEGAL;
                end
            end
            S_TRAP: begin
                halt_s  = 1'b1;
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
                err_d   = ERR_ILLEGAL;
            end
        endcase

        // A state change means a fresh wait, so the watchdog only runs while stalled in place
        if (in_mem_s && !mem_ready && (state_d == state_q)) begin
            wdog_d = wdog_q + 8'd1;
        end else begin
            wdog_d = 8'd0;
        end
    end

    assign mem_req     = req_s  & ~reset;
    assign mem_we      = we_s   & ~reset;
    assign adr_src     = adr_s  & ~reset;
    assign ir_write    = irw_s  & ~reset;
    assign pc_write    = pcw_s  & ~reset;
    assign reg_write   = rw_s   & ~reset;
    assign inst_done   = done_s & ~reset;
    assign halted      = halt_s & ~reset;
    assign alu_src_a   = reset ? 2'b00   : src_a_s;
    assign alu_src_b   = reset ? 2'b00   : src_b_s;
    assign result_src  = reset ? 2'b00   : res_s;
    assign alu_control = reset ? 4'b0000 : alu_s;
    assign err_code    = reset ? 2'b00   : err_q;
    assign state       = reset ? 4'd0    : state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: directed test-plan segments with literal
// expectations, then randomized instructions/handshakes against an instruction-level model.
module tb_rv_multicycle_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst = 32'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, inst_done, halted;
    logic [1:0]  alu_src_a, alu_src_b, result_src, err_code;
    logic [3:0]  alu_control, state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;

    // Model: remaining step list of the current instruction, wait count and latched error
    int          m_seq[$];
    logic [31:0] m_inst = 32'd0;
    int          m_wait = 0;
    int          m_err = 0;
    logic [31:0] next_inst = 32'd0;

    int exp_r   [4] = '{0, 1, 6, 7};
    int exp_lw  [7] = '{0, 1, 2, 3, 3, 3, 4};
    int rdy_lw  [7] = '{1, 1, 1, 0, 0, 1, 1};
    int exp_beq [3] = '{0, 1, 8};

    rv_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .inst(inst), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .result_src(result_src), .reg_write(reg_write),
        .inst_done(inst_done), .halted(halted), .err_code(err_code), .state(state)
    );

    always #5 clk = ~clk;

    // ALU op for an R-type instruction, -1 when the funct combination is unsupported
    function automatic int r_alu_op(logic [31:0] w);
        if (w[30] == 1'b0 && w[14:12] == 3'd0) return 2;
        if (w[30] == 1'b1 && w[14:12] == 3'd0) return 6;
        if (w[30] == 1'b0 && w[14:12] == 3'd7) return 0;
        if (w[30] == 1'b0 && w[14:12] == 3'd6) return 1;
        return -1;
    endfunction

    function automatic void load_inst(logic [31:0] w);
        m_inst = w;
        m_seq = {0, 1};
        case (w[6:0])
            7'h03: begin m_seq.push_back(2); m_seq.push_back(3); m_seq.push_back(4); end
            7'h23: begin m_seq.push_back(2); m_seq.push_back(5); end
            7'h33: begin m_seq.push_back(6); m_seq.push_back(r_alu_op(w) < 0 ? 9 : 7); end
            7'h63: begin m_seq.push_back(8); if (w[14:12] != 3'd0) m_seq.push_back(9); end
            default: m_seq.push_back(9);
        endcase
    endfunction

    function automatic logic [23:0] expect_out(int st, logic [31:0] w, logic z, logic rdy, int err);
        logic req = 1'b0, we = 1'b0, adr = 1'b0, irw = 1'b0, pcw = 1'b0;
        logic rw = 1'b0, done = 1'b0, halt = 1'b0;
        logic [1:0] a = 2'd0, b = 2'd0, rs = 2'd0;
        logic [3:0] ctl = 4'b0010;
        logic [3:0] st4 = 4'(st);
        case (st)
            0: begin req = 1'b1; b = 2'd2; rs = 2'd2; irw = rdy; pcw = rdy; end
            1: begin a = 2'd1; b = 2'd1; end
            2: begin a = 2'd2; b = 2'd1; end
            3: begin req = 1'b1; adr = 1'b1; end
            4: begin rw = 1'b1; rs = 2'd1; done = 1'b1; end
            5: begin req = 1'b1; we = 1'b1; adr = 1'b1; done = rdy; end
            6: begin a = 2'd2; if (r_alu_op(w) >= 0) ctl = 4'(r_alu_op(w)); end
            7: begin rw = 1'b1; done = 1'b1; end
            8: begin
                a = 2'd2; ctl = 4'b0110;
                if (w[14:12] == 3'd0) begin pcw = z; done = 1'b1; end
            end
            default: halt = 1'b1;
        endcase
        return {req, we, adr, irw, pcw, a, b, ctl, rs, rw, done, halt, 2'(err), st4};
    endfunction

    task automatic check_v(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // One clock: drive inputs, compare every output against the model, advance the model
    task automatic step(input logic rst, input logic rdy, input logic z);
        int cur;
        logic [23:0] got, exp;
        @(negedge clk);
        if (m_seq.size() == 0) load_inst(next_inst);
        cur = m_seq[0];
        reset = rst;
        mem_ready = rdy;
        zero = z;
        inst = m_inst;
        #1;
        got = {mem_req, mem_we, adr_src, ir_write, pc_write, alu_src_a, alu_src_b,
               alu_control, result_src, reg_write, inst_done, halted, err_code, state};
        exp = rst ? 24'd0 : expect_out(cur, m_inst, z, rdy, m_err);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL outputs cyc=%0d model_state=%0d got=%h expected=%h", cyc, cur, got, exp);
        end
        if (inst_done === 1'b1) done_cnt++;
        if (rst) begin
            m_seq.delete();
            m_wait = 0;
            m_err = 0;
        end else if (cur == 9) begin
            m_wait = 0;
        end else if ((cur == 0 || cur == 3 || cur == 5) && !rdy) begin
            m_wait++;
            if (m_wait == TO) begin
                m_seq = {9};
                m_err = 2;
                m_wait = 0;
            end
        end else begin
            m_wait = 0;
            void'(m_seq.pop_front());
            if (m_seq.size() > 0 && m_seq[0] == 9) m_err = 1;
        end
        cyc++;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        logic [3:0] fn [4] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110};
        logic [3:0] f;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        f = fn[$urandom_range(0, 3)];
        case (k)
            0, 1, 2, 3: begin w[6:0] = 7'h33; w[30] = f[3]; w[14:12] = f[2:0]; end
            4: w[6:0] = 7'h03;
            5: w[6:0] = 7'h23;
            6: begin w[6:0] = 7'h63; w[14:12] = 3'd0; end
            7: begin w[6:0] = 7'h33; w[14:12] = 3'b001; end
            8: begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(1, 7)); end
            default: w[6:0] = ($urandom_range(0, 1) == 0) ? 7'h13 : w[6:0];
        endcase
        return w;
    endfunction

    initial begin
        int trap_cycles;
        logic rst_r, rdy_r;
        next_inst = 32'h002081B3;
        step(1'b1, 1'b1, 1'b0);
        check_v("reset_state", {28'd0, state}, 32'd0);
        check_v("reset_mem_req", {31'd0, mem_req}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check_v("reset_halted", {31'd0, halted}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check_v("add_state", {28'd0, state}, 32'(exp_r[i]));
            if (i == 2) check_v("add_alu_control", {28'd0, alu_control}, 32'h2);
        end
        check_v("add_reg_write", {31'd0, reg_write}, 32'd1);
        check_v("add_inst_done", {31'd0, inst_done}, 32'd1);

        next_inst = 32'h402081B3;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check_v("sub_state", {28'd0, state}, 32'(exp_r[i]));
            if (i == 2) check_v("sub_alu_control", {28'd0, alu_control}, 32'h6);
        end

        next_inst = 32'h0000A183;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, rdy_lw[i][0], 1'b0);
            check_v("lw_state", {28'd0, state}, 32'(exp_lw[i]));
            if (exp_lw[i] == 3) check_v("lw_req_adr", {30'd0, mem_req, adr_src}, 32'd3);
        end
        check_v("lw_result_src", {30'd0, result_src}, 32'd1);
        check_v("lw_inst_done", {31'd0, inst_done}, 32'd1);

        next_inst = 32'h00208463;
        for (int zz = 1; zz >= 0; zz--) begin
            for (int i = 0; i < 3; i++) begin
                step(1'b0, 1'b1, zz[0]);
                check_v("beq_state", {28'd0, state}, 32'(exp_beq[i]));
            end
            check_v("beq_pc_write", {31'd0, pc_write}, 32'(zz));
            check_v("beq_inst_done", {31'd0, inst_done}, 32'd1);
        end

        next_inst = 32'h00000013;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_v("ill_decode", {28'd0, state}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0);
            check_v("ill_trap", {26'd0, halted, err_code, state}, {26'd0, 1'b1, 2'b01, 4'd9});
        end
        step(1'b1, 1'b1, 1'b0);
        next_inst = 32'h002081B3;
        step(1'b0, 1'b0, 1'b0);
        check_v("ill_reset_fetch", {28'd0, state}, 32'd0);

        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < TO; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check_v("tmo_fetch", {27'd0, mem_req, state}, {27'd0, 1'b1, 4'd0});
        end
        step(1'b0, 1'b0, 1'b0);
        check_v("tmo_trap", {25'd0, mem_req, halted, err_code, state}, {25'd0, 1'b0, 1'b1, 2'b10, 4'd9});

        step(1'b1, 1'b0, 1'b0);
        next_inst = 32'h0020A023;
        done_cnt = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_v("sw_reset_outs", {26'd0, mem_req, mem_we, state}, 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check_v("sw_after_reset", {28'd0, state}, 32'd0);
        check_v("sw_no_done", 32'(done_cnt), 32'd0);

        trap_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_seq.size() == 0) next_inst = rand_inst();
            rst_r = ($urandom_range(0, 299) == 0) || (trap_cycles > 4);
            rdy_r = ($urandom_range(0, 3) != 0);
            step(rst_r, rdy_r, 1'($urandom_range(0, 1)));
            if (m_seq.size() > 0 && m_seq[0] == 9) trap_cycles++;
            else trap_cycles = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
